// File: rtl/sd_mount_pkg.sv
// Shared types and helpers for the virtual/physical SD mount multiplexer.
// Holds the reset sequencer states, default constants and the chip-select priority helper.
package sd_mount_pkg;

    localparam int MAX_CS             = 8;
    localparam int DEF_N_CS           = 2;
    localparam int DEF_PHYS_CH        = 0;
    localparam int DEF_RST_CYCLES     = 10000000;
    localparam int DEF_ACT_CYCLES     = 1000000;
    localparam int DEF_CNT_W          = 24;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rst_state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } cs_sel_t;

    // Lowest-index asserted (low) chip select; hit=0 when none is active.
    function automatic cs_sel_t lowest_cs(input logic [MAX_CS-1:0] cs_n);
        cs_sel_t r;
        r.hit = 1'b0;
        r.idx = 3'd0;
        for (int i = MAX_CS - 1; i >= 0; i--) begin
            if (!cs_n[i]) begin
                r.hit = 1'b1;
                r.idx = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sd_act_timer.sv
// Per-channel SPI activity detector: any MOSI/MISO data edge while selected
// restarts a saturating hold timer; act stays high until the timer expires.
module sd_act_timer
    import sd_mount_pkg::*;
#(
    parameter int ACT_CYCLES = DEF_ACT_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic cs_n,
    input  logic mosi,
    input  logic miso,
    output logic act
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(ACT_CYCLES);

    logic             mosi_q;
    logic             miso_q;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nxt;
    logic             edge_hit;

    always_comb begin
        edge_hit = ~cs_n & ((mosi ^ mosi_q) | (miso ^ miso_q));
        if (edge_hit)
            timer_nxt = '0;
        else if (timer < SAT)
            timer_nxt = timer + 1'b1;
        else
            timer_nxt = timer;
    end

    // act is taken from the next timer value so it rises on the clearing edge itself.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            mosi_q <= 1'b1;
            miso_q <= 1'b1;
            timer  <= SAT;
            act    <= 1'b0;
        end else begin
            mosi_q <= mosi;
            miso_q <= miso;
            timer  <= timer_nxt;
            act    <= (timer_nxt < SAT);
        end
    end

endmodule

// File: rtl/sd_mount_mux.sv
// Routes the core SPI master to mounted virtual images or the physical SD slot,
// and generates the mount-triggered core reset pulse and activity LEDs.
module sd_mount_mux
    import sd_mount_pkg::*;
#(
    parameter int N_CS       = DEF_N_CS,
    parameter int PHYS_CH    = DEF_PHYS_CH,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int ACT_CYCLES = DEF_ACT_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic            clk_sys,
    input  logic            RESET_N,
    input  logic [N_CS-1:0] img_mounted,
    input  logic [N_CS-1:0] img_present,
    input  logic            spi_sck,
    input  logic            spi_mosi,
    input  logic [N_CS-1:0] spi_cs_n,
    output logic            spi_miso,
    input  logic [N_CS-1:0] vsd_miso,
    output logic [N_CS-1:0] vsd_ss_n,
    output logic [N_CS-1:0] vsd_sel,
    input  logic            SD_MISO,
    output logic            SD_CS,
    output logic            SD_SCK,
    output logic            SD_MOSI,
    output logic            reset_img,
    output logic [N_CS-1:0] act,
    output logic            led_virt,
    output logic            led_phys
);

    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);

    logic [N_CS-1:0]   eff_miso;
    logic [MAX_CS-1:0] cs_pad;
    logic [MAX_CS-1:0] miso_pad;
    cs_sel_t           cs_sel;

    rst_state_t        state, state_nxt;
    logic [CNT_W-1:0]  rst_cnt, rst_cnt_nxt;

    // Each strobed channel loads its present flag; untouched channels keep state.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N)
            vsd_sel <= '0;
        else
            vsd_sel <= (vsd_sel & ~img_mounted) | (img_present & img_mounted);
    end

    assign vsd_ss_n = ~vsd_sel | spi_cs_n;

    assign SD_CS   = vsd_sel[PHYS_CH] | spi_cs_n[PHYS_CH];
    assign SD_SCK  = spi_sck  & ~SD_CS;
    assign SD_MOSI = spi_mosi & ~SD_CS;

    for (genvar c = 0; c < N_CS; c++) begin : g_ch
        if (c == PHYS_CH) begin : g_phys
            assign eff_miso[c] = vsd_sel[c] ? vsd_miso[c] : SD_MISO;
        end else begin : g_virt
            assign eff_miso[c] = vsd_sel[c] ? vsd_miso[c] : 1'b1;
        end

        sd_act_timer #(
            .ACT_CYCLES (ACT_CYCLES),
            .CNT_W      (CNT_W)
        ) u_act (
            .clk_sys (clk_sys),
            .rst_n   (RESET_N),
            .cs_n    (spi_cs_n[c]),
            .mosi    (spi_mosi),
            .miso    (eff_miso[c]),
            .act     (act[c])
        );
    end

    // Unused upper lanes are padded inactive so the helper works on a fixed width.
    always_comb begin
        cs_pad              = '1;
        cs_pad[N_CS-1:0]    = spi_cs_n;
        miso_pad            = '1;
        miso_pad[N_CS-1:0]  = eff_miso;
        cs_sel              = lowest_cs(cs_pad);
        spi_miso            = cs_sel.hit ? miso_pad[cs_sel.idx] : 1'b1;
    end

    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        case (state)
            IDLE: begin
                if (|img_mounted) begin
                    state_nxt   = HOLD;
                    rst_cnt_nxt = RST_LOAD;
                end
            end
            HOLD: begin
                if (|img_mounted)
                    rst_cnt_nxt = RST_LOAD;
                else if (rst_cnt == '0)
                    state_nxt = IDLE;
                else
                    rst_cnt_nxt = rst_cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            rst_cnt <= '1;
        end else begin
            state   <= state_nxt;
            rst_cnt <= rst_cnt_nxt;
        end
    end

    assign reset_img = (state == HOLD);

    assign led_virt = |(act & vsd_sel);
    assign led_phys = act[PHYS_CH] & ~vsd_sel[PHYS_CH];

endmodule
